// File: rtl/mem_bus_pkg.sv
// rtl/mem_bus_pkg.sv - shared encodings, state enum and decode helper for the CPU memory/IO bus
package mem_bus_pkg;

  localparam logic [1:0] MNONE  = 2'b00;
  localparam logic [1:0] MREAD  = 2'b01;
  localparam logic [1:0] MWRITE = 2'b10;

  localparam logic [8:0] LED_ADDR_DEF = 9'h100;
  localparam logic [8:0] SW_ADDR_DEF  = 9'h140;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RAM_RD,
    ST_RAM_WR,
    ST_DONE
  } state_t;

  typedef enum logic [1:0] {
    TGT_RAM,
    TGT_LED,
    TGT_SW,
    TGT_NONE
  } target_t;

  // Upper address bit clear selects RAM; the IO registers are exact-match only.
  function automatic target_t decode_target(input logic [8:0] addr,
                                            input logic [8:0] led_addr,
                                            input logic [8:0] sw_addr);
    if (!addr[8])               return TGT_RAM;
    else if (addr == led_addr)  return TGT_LED;
    else if (addr == sw_addr)   return TGT_SW;
    else                        return TGT_NONE;
  endfunction

endpackage

// File: rtl/sync2.sv
// rtl/sync2.sv - two-flop synchroniser with asynchronous active-low clear
module sync2 #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q, meta_d;
  logic [WIDTH-1:0] sync_q, sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/mem_bus_ctrl.sv
// rtl/mem_bus_ctrl.sv - CPU memory-port controller sequencing the 256x16 RAM and switch/LED IO
module mem_bus_ctrl
  import mem_bus_pkg::*;
#(
  parameter int         DATA_W   = 16,
  parameter int         ADDR_W   = 9,
  parameter int         RAM_AW   = 8,
  parameter logic [8:0] LED_ADDR = LED_ADDR_DEF,
  parameter logic [8:0] SW_ADDR  = SW_ADDR_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [1:0]        mem_cmd,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] write_data,
  output logic [DATA_W-1:0] read_data,
  output logic              mem_ready,
  output logic              bus_err,
  output logic [RAM_AW-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout,
  input  logic [7:0]        sw,
  output logic [7:0]        ledr
);

  logic [7:0] sw_sync;

  sync2 #(.WIDTH(8)) u_sw_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (sw),
    .q       (sw_sync)
  );

  state_t            state_q, state_d;
  logic [DATA_W-1:0] read_data_q, read_data_d;
  logic              mem_ready_q, mem_ready_d;
  logic              bus_err_q, bus_err_d;
  logic [RAM_AW-1:0] ram_addr_q, ram_addr_d;
  logic              ram_we_q, ram_we_d;
  logic [DATA_W-1:0] ram_din_q, ram_din_d;
  logic [7:0]        ledr_q, ledr_d;

  target_t target;
  logic    is_access;
  logic    is_write;

  always_comb begin
    target    = decode_target(mem_addr, LED_ADDR, SW_ADDR);
    is_access = (mem_cmd == MREAD) || (mem_cmd == MWRITE);
    is_write  = (mem_cmd == MWRITE);

    state_d     = state_q;
    read_data_d = read_data_q;
    mem_ready_d = 1'b0;
    bus_err_d   = bus_err_q;
    ram_addr_d  = ram_addr_q;
    ram_we_d    = 1'b0;
    ram_din_d   = ram_din_q;
    ledr_d      = ledr_q;

    // Address and store data are captured into the output registers on the
    // accepting edge, so later mem_cmd/mem_addr changes cannot disturb the access.
    unique case (state_q)
      ST_IDLE: begin
        if (is_access) begin
          unique case (target)
            TGT_RAM: begin
              ram_addr_d = mem_addr[RAM_AW-1:0];
              if (is_write) begin
                ram_din_d = write_data;
                ram_we_d  = 1'b1;
                state_d   = ST_RAM_WR;
              end else begin
                state_d = ST_RAM_RD;
              end
            end
            TGT_LED: begin
              if (is_write) ledr_d = write_data[7:0];
              else          read_data_d = '0;
              mem_ready_d = 1'b1;
              state_d     = ST_DONE;
            end
            TGT_SW: begin
              if (is_write) read_data_d = '0;
              else          read_data_d = {{(DATA_W-8){1'b0}}, sw_sync};
              mem_ready_d = 1'b1;
              state_d     = ST_DONE;
            end
            default: begin
              read_data_d = '0;
              bus_err_d   = 1'b1;
              mem_ready_d = 1'b1;
              state_d     = ST_DONE;
            end
          endcase
        end
      end
      ST_RAM_RD: begin
        read_data_d = ram_dout;
        mem_ready_d = 1'b1;
        state_d     = ST_DONE;
      end
      ST_RAM_WR: begin
        mem_ready_d = 1'b1;
        state_d     = ST_DONE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      read_data_q <= '0;
      mem_ready_q <= 1'b0;
      bus_err_q   <= 1'b0;
      ram_addr_q  <= '0;
      ram_we_q    <= 1'b0;
      ram_din_q   <= '0;
      ledr_q      <= '0;
    end else begin
      state_q     <= state_d;
      read_data_q <= read_data_d;
      mem_ready_q <= mem_ready_d;
      bus_err_q   <= bus_err_d;
      ram_addr_q  <= ram_addr_d;
      ram_we_q    <= ram_we_d;
      ram_din_q   <= ram_din_d;
      ledr_q      <= ledr_d;
    end
  end

  assign read_data = read_data_q;
  assign mem_ready = mem_ready_q;
  assign bus_err   = bus_err_q;
  assign ram_addr  = ram_addr_q;
  assign ram_we    = ram_we_q;
  assign ram_din   = ram_din_q;
  assign ledr      = ledr_q;

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// tb/tb_mem_bus_ctrl.sv - scoreboard bench for mem_bus_ctrl with a behavioural 256x16 RAM
module tb_mem_bus_ctrl;

  localparam logic [1:0] C_NONE  = 2'b00;
  localparam logic [1:0] C_READ  = 2'b01;
  localparam logic [1:0] C_WRITE = 2'b10;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  mem_cmd;
  logic [8:0]  mem_addr;
  logic [15:0] write_data;
  logic [15:0] read_data;
  logic        mem_ready;
  logic        bus_err;
  logic [7:0]  ram_addr;
  logic        ram_we;
  logic [15:0] ram_din;
  logic [15:0] ram_dout;
  logic [7:0]  sw;
  logic [7:0]  ledr;

  always #5 clk = ~clk;

  mem_bus_ctrl dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .mem_cmd    (mem_cmd),
    .mem_addr   (mem_addr),
    .write_data (write_data),
    .read_data  (read_data),
    .mem_ready  (mem_ready),
    .bus_err    (bus_err),
    .ram_addr   (ram_addr),
    .ram_we     (ram_we),
    .ram_din    (ram_din),
    .ram_dout   (ram_dout),
    .sw         (sw),
    .ledr       (ledr)
  );

  // RAM: data for the registered address is available during the following cycle.
  logic [15:0] mem [256];
  logic        load_en;

  always @(posedge clk) begin
    if (load_en) begin
      for (int i = 0; i < 256; i++) mem[i] <= 16'h0000;
      mem[0] <= 16'h1111;
      mem[5] <= 16'hABCD;
    end else if (ram_we) begin
      mem[ram_addr] <= ram_din;
    end
  end

  assign ram_dout = mem[ram_addr];

  int checks = 0;
  int errors = 0;
  int ready_cnt = 0;
  int we_cnt = 0;
  logic [7:0] last_we_addr = 8'h00;

  logic [15:0] sb_rd[$];
  logic        sb_err[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every completion pulse is matched against the oldest expected response.
  initial begin
    forever begin
      @(negedge clk);
      if (ram_we === 1'b1) begin
        we_cnt++;
        last_we_addr = ram_addr;
      end
      if (mem_ready === 1'b1) begin
        ready_cnt++;
        if (sb_rd.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_ready: got mem_ready=1 with no request outstanding");
        end else begin
          chk("sb_read_data", {16'h0, read_data}, {16'h0, sb_rd.pop_front()});
          chk("sb_bus_err", {31'h0, bus_err}, {31'h0, sb_err.pop_front()});
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  task automatic expect_resp(input logic [15:0] rd, input logic err);
    sb_rd.push_back(rd);
    sb_err.push_back(err);
  endtask

  // Drive one request at a negedge and hold it until mem_ready is seen.
  task automatic issue(input string name, input logic [1:0] c, input logic [8:0] a,
                       input logic [15:0] d, input logic [15:0] exp_rd, input logic exp_err,
                       input int exp_lat);
    int  lat;
    bit  got;
    expect_resp(exp_rd, exp_err);
    @(negedge clk);
    mem_cmd = c; mem_addr = a; write_data = d;
    lat = 0; got = 0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      lat++;
      if (mem_ready === 1'b1) got = 1;
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got no mem_ready within 10 clocks, expected one", name);
    end else begin
      chk({name, "_latency"}, lat, exp_lat);
    end
    @(posedge clk);
    #1 mem_cmd = C_NONE;
  endtask

  int we0, rdy0;

  initial begin
    reset_n = 1'b0; load_en = 1'b1;
    mem_cmd = C_NONE; mem_addr = 9'h000; write_data = 16'h0000; sw = 8'h81;
    repeat (3) @(posedge clk);
    #1 load_en = 1'b0;
    @(negedge clk);
    chk("rst_read_data", {16'h0, read_data}, 32'h0);
    chk("rst_mem_ready", {31'h0, mem_ready}, 32'h0);
    chk("rst_bus_err", {31'h0, bus_err}, 32'h0);
    chk("rst_ram_addr", {24'h0, ram_addr}, 32'h0);
    chk("rst_ram_we", {31'h0, ram_we}, 32'h0);
    chk("rst_ram_din", {16'h0, ram_din}, 32'h0);
    chk("rst_ledr", {24'h0, ledr}, 32'h0);
    reset_n = 1'b1;

    // RAM load
    we0 = we_cnt;
    issue("rd005", C_READ, 9'h005, 16'hFFFF, 16'hABCD, 1'b0, 2);
    chk("rd005_no_we", we_cnt - we0, 0);

    // RAM store, then load it back; read_data keeps the previous load across the store
    we0 = we_cnt;
    issue("wr006", C_WRITE, 9'h006, 16'hABCD, 16'hABCD, 1'b0, 2);
    chk("wr006_we_pulses", we_cnt - we0, 1);
    chk("wr006_ram_addr", {24'h0, last_we_addr}, 32'h06);
    chk("wr006_mem", {16'h0, mem[6]}, 32'hABCD);
    issue("rd006", C_READ, 9'h006, 16'h0000, 16'hABCD, 1'b0, 2);

    // LED store and switch load through the synchroniser
    we0 = we_cnt;
    issue("wr_led", C_WRITE, 9'h100, 16'h12A5, 16'hABCD, 1'b0, 1);
    chk("led_value", {24'h0, ledr}, 32'hA5);
    chk("led_no_we", we_cnt - we0, 0);
    sw = 8'h3C;
    repeat (3) @(posedge clk);
    issue("rd_sw", C_READ, 9'h140, 16'h0000, 16'h003C, 1'b0, 1);
    issue("rd_led", C_READ, 9'h100, 16'h0000, 16'h0000, 1'b0, 1);
    chk("led_kept", {24'h0, ledr}, 32'hA5);

    // Unmapped access sets the sticky error; last RAM word still maps
    issue("rd_1f0", C_READ, 9'h1F0, 16'h0000, 16'h0000, 1'b1, 1);
    issue("rd_0ff", C_READ, 9'h0FF, 16'h0000, 16'h0000, 1'b1, 2);
    issue("rd005b", C_READ, 9'h005, 16'h0000, 16'hABCD, 1'b1, 2);
    chk("bus_err_sticky", {31'h0, bus_err}, 32'h1);

    // Reset in the middle of a RAM store
    @(negedge clk);
    mem_cmd = C_WRITE; mem_addr = 9'h007; write_data = 16'h1234;
    @(posedge clk);
    #1 chk("t1_we_set", {31'h0, ram_we}, 32'h1);
    #2 reset_n = 1'b0;
    #1;
    chk("t1_we_cleared", {31'h0, ram_we}, 32'h0);
    chk("t1_ledr", {24'h0, ledr}, 32'h0);
    chk("t1_mem_ready", {31'h0, mem_ready}, 32'h0);
    chk("t1_bus_err", {31'h0, bus_err}, 32'h0);
    mem_cmd = C_NONE;
    @(posedge clk);
    @(negedge clk);
    chk("t1_mem7_unchanged", {16'h0, mem[7]}, 32'h0);
    reset_n = 1'b1;

    // Back-to-back: mem_cmd changes while the read is in flight
    rdy0 = ready_cnt;
    expect_resp(16'h1111, 1'b0);
    expect_resp(16'h1111, 1'b0);
    @(negedge clk);
    mem_cmd = C_READ; mem_addr = 9'h000; write_data = 16'h0000;
    @(posedge clk);
    #1 mem_cmd = C_WRITE; mem_addr = 9'h001; write_data = 16'h5A5A;
    for (int i = 0; i < 20 && (ready_cnt - rdy0) < 2; i++) @(negedge clk);
    @(posedge clk);
    #1 mem_cmd = C_NONE;
    repeat (4) @(negedge clk);
    chk("b2b_ready_pulses", ready_cnt - rdy0, 2);
    chk("b2b_mem1", {16'h0, mem[1]}, 32'h5A5A);
    chk("b2b_mem0", {16'h0, mem[0]}, 32'h1111);
    issue("rd001", C_READ, 9'h001, 16'h0000, 16'h5A5A, 1'b0, 2);

    repeat (3) @(negedge clk);
    chk("sb_drained", sb_rd.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
